// File: rtl/tcam_pkg.sv
// Shared TCAM constants and the match-resolver state encoding.
package tcam_pkg;

  localparam int NUM_RULES = 120;
  localparam int RULE_W    = 104;
  localparam int IDX_W     = 7;
  localparam int CNT_W     = 8;

  // A single rule bit at position 0, used to build per-rule masks and decrements.
  localparam logic [NUM_RULES-1:0] RULE_ONE = NUM_RULES'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    MISS = 2'd2
  } state_t;

endpackage

// File: rtl/tcam_prio_enc.sv
// Lowest-index-wins priority encoder over the rule vector, with a flag for
// "exactly one bit set" so the resolver knows when the current hit is the final one.
module tcam_prio_enc
  import tcam_pkg::*;
(
  input  logic [NUM_RULES-1:0] vec,
  output logic [IDX_W-1:0]     idx,
  output logic                 any,
  output logic                 onehot
);

  // Scan from the top down so that the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any    = |vec;
  assign onehot = any && ((vec & (vec - RULE_ONE)) == '0);

endmodule

// File: rtl/tcam_match_resolver.sv
// Consumes one TCAM match vector per lookup and streams out the matching rule
// indices in priority order, or a single miss beat when nothing matched.
module tcam_match_resolver
  import tcam_pkg::*;
(
  input  logic                 write_clk,
  input  logic                 reset,
  input  logic                 match_valid,
  output logic                 match_ready,
  input  logic [NUM_RULES-1:0] match_vec,
  input  logic                 first_only,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_miss,
  output logic                 out_last,
  output logic [CNT_W-1:0]     hit_count,
  output logic                 busy
);

  state_t               state_q, state_d;
  logic [NUM_RULES-1:0] pend_q, pend_d;
  logic                 mode_q, mode_d;
  logic [CNT_W-1:0]     hit_count_q, hit_count_d;
  logic [CNT_W-1:0]     popcnt;
  logic                 ready_q, ready_d;
  logic [IDX_W-1:0]     enc_idx;
  logic                 enc_any;
  logic                 enc_onehot;

  tcam_prio_enc u_prio_enc (
    .vec    (pend_q),
    .idx    (enc_idx),
    .any    (enc_any),
    .onehot (enc_onehot)
  );

  // Hit count of the incoming vector, taken at capture time.
  always_comb begin
    popcnt = '0;
    for (int i = 0; i < NUM_RULES; i++) begin
      popcnt = popcnt + CNT_W'(match_vec[i]);
    end
  end

  // Next-state and stream outputs; each accepted hit is cleared from the pending vector.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    mode_d      = mode_q;
    hit_count_d = hit_count_q;
    out_valid   = 1'b0;
    out_idx     = '0;
    out_miss    = 1'b0;
    out_last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready_q && match_valid) begin
          pend_d      = match_vec;
          mode_d      = first_only;
          hit_count_d = popcnt;
          state_d     = (|match_vec) ? EMIT : MISS;
        end
      end
      EMIT: begin
        out_valid = enc_any;
        out_idx   = enc_idx;
        out_last  = mode_q || enc_onehot;
        if (out_valid && out_ready) begin
          if (out_last) begin
            pend_d  = '0;
            state_d = IDLE;
          end else begin
            pend_d = pend_q & ~(RULE_ONE << enc_idx);
          end
        end
      end
      MISS: begin
        out_valid = 1'b1;
        out_miss  = 1'b1;
        out_last  = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready only after a full cycle spent in IDLE, which leaves a one-cycle bubble between lookups.
  always_comb begin
    ready_d = (state_d == IDLE) && (state_q == IDLE);
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge write_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      mode_q      <= 1'b0;
      hit_count_q <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      mode_q      <= mode_d;
      hit_count_q <= hit_count_d;
      ready_q     <= ready_d;
    end
  end

  assign match_ready = ready_q;
  assign hit_count   = hit_count_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_tcam_match_resolver.sv
// Directed bench for the match resolver: expected beats are queued when a
// vector is offered and compared as the resolver hands each beat over.
module tb_tcam_match_resolver;

  localparam int NR = 120;

  typedef struct {
    logic [6:0] idx;
    logic       miss;
    logic       last;
  } beat_t;

  logic          write_clk;
  logic          reset;
  logic          match_valid;
  logic          match_ready;
  logic [NR-1:0] match_vec;
  logic          first_only;
  logic          out_valid;
  logic          out_ready;
  logic [6:0]    out_idx;
  logic          out_miss;
  logic          out_last;
  logic [7:0]    hit_count;
  logic          busy;

  beat_t sbQueue[$];
  int    checkCount = 0;
  int    passCount  = 0;
  int    failCount  = 0;

  tcam_match_resolver dut (
    .write_clk   (write_clk),
    .reset       (reset),
    .match_valid (match_valid),
    .match_ready (match_ready),
    .match_vec   (match_vec),
    .first_only  (first_only),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_miss    (out_miss),
    .out_last    (out_last),
    .hit_count   (hit_count),
    .busy        (busy)
  );

  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  // Offer one vector, queue the beats it should produce, and check the captured hit count.
  task automatic applyStimulus(input logic [NR-1:0] vec, input logic fo);
    int    w;
    int    nHits;
    beat_t b;
    w = 0;
    while (!match_ready && w < 20) begin
      tick();
      w++;
    end
    checkOutput("ready_wait", match_ready, 1);
    nHits = $countones(vec);
    if (nHits == 0) begin
      b.idx = 7'd0; b.miss = 1'b1; b.last = 1'b1;
      sbQueue.push_back(b);
    end else begin
      int seen;
      seen = 0;
      for (int i = 0; i < NR; i++) begin
        if (vec[i] && !(fo && seen > 0)) begin
          seen++;
          b.idx  = 7'(i);
          b.miss = 1'b0;
          b.last = fo || (seen == nHits);
          sbQueue.push_back(b);
        end
      end
    end
    match_valid = 1'b1;
    match_vec   = vec;
    first_only  = fo;
    tick();
    match_valid = 1'b0;
    checkOutput("hit_count", hit_count, nHits);
    checkOutput("busy_after_capture", busy, 1);
  endtask

  // Pop and compare each beat as the handshake is about to complete.
  task automatic drainBeats(input int budget, output int cycles);
    beat_t e;
    cycles = 0;
    while (sbQueue.size() > 0 && cycles < budget) begin
      if (out_valid && out_ready) begin
        e = sbQueue.pop_front();
        checkOutput("beat_idx", out_idx, e.idx);
        checkOutput("beat_miss", out_miss, e.miss);
        checkOutput("beat_last", out_last, e.last);
      end
      tick();
      cycles++;
    end
    if (sbQueue.size() != 0) checkOutput("drain_timeout", sbQueue.size(), 0);
  endtask

  initial begin
    logic [NR-1:0] v;
    int            cyc;
    beat_t         e;

    reset       = 1'b1;
    match_valid = 1'b0;
    match_vec   = '0;
    first_only  = 1'b0;
    out_ready   = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checkOutput("rst_match_ready", match_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_hit_count", hit_count, 0);
    checkOutput("rst_busy", busy, 0);

    $display("[TB] three hits, streaming");
    out_ready = 1'b1;
    v = '0; v[3] = 1'b1; v[17] = 1'b1; v[119] = 1'b1;
    applyStimulus(v, 1'b0);
    drainBeats(10, cyc);
    checkOutput("three_hit_cycles", cyc, 3);
    checkOutput("bubble_ready_low", match_ready, 0);
    tick();
    checkOutput("bubble_ready_high", match_ready, 1);

    $display("[TB] miss");
    applyStimulus('0, 1'b0);
    drainBeats(10, cyc);
    checkOutput("miss_cycles", cyc, 1);

    $display("[TB] all ones, first only");
    v = '1;
    applyStimulus(v, 1'b1);
    drainBeats(10, cyc);
    checkOutput("first_only_cycles", cyc, 1);

    $display("[TB] all ones, full stream");
    applyStimulus(v, 1'b0);
    drainBeats(200, cyc);
    checkOutput("all_ones_cycles", cyc, 120);

    $display("[TB] stall with ignored captures");
    out_ready = 1'b0;
    v = '0; v[5] = 1'b1; v[6] = 1'b1;
    applyStimulus(v, 1'b0);
    for (int s = 0; s < 4; s++) begin
      checkOutput("stall_valid", out_valid, 1);
      checkOutput("stall_idx", out_idx, 5);
      checkOutput("stall_last", out_last, 0);
      match_valid = 1'b1;
      match_vec   = NR'($urandom) | (NR'(1) << 40);
      tick();
    end
    match_valid = 1'b0;
    out_ready   = 1'b1;
    drainBeats(10, cyc);
    checkOutput("stall_hit_count", hit_count, 2);
    tick();
    tick();
    checkOutput("stall_no_capture", out_valid, 0);

    $display("[TB] reset mid-stream");
    v = '0; v[10] = 1'b1; v[20] = 1'b1;
    applyStimulus(v, 1'b0);
    e = sbQueue.pop_front();
    checkOutput("midrst_first_idx", out_idx, e.idx);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sbQueue.delete();
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_match_ready", match_ready, 1);
    checkOutput("midrst_hit_count", hit_count, 0);
    checkOutput("midrst_busy", busy, 0);
    v = '0; v[2] = 1'b1;
    applyStimulus(v, 1'b0);
    drainBeats(10, cyc);
    checkOutput("after_rst_cycles", cyc, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
